// File: rtl/bcd_counter_ndigit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_pkg
// Purpose  : Shared BCD types, constants and helpers for the N-digit
//            packed-BCD counter.
// Contents : BCD_MAX_DIGIT  largest legal BCD digit value (9)
//            bcd_digit_t    one packed BCD digit
//            bcd_valid()    1 when a nibble is a legal BCD digit (0..9)
// Revision : 1.0  initial release
// ============================================================================
package bcd_pkg;

    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

    typedef logic [3:0] bcd_digit_t;

    function automatic logic bcd_valid(input bcd_digit_t nibble);
        return (nibble <= BCD_MAX_DIGIT);
    endfunction

endpackage : bcd_pkg
`default_nettype wire

// File: rtl/bcd_counter_ndigit_if.sv
`default_nettype none
// ============================================================================
// Module   : bcd_counter_ndigit_if
// Purpose  : Control / status bundle of the N-digit BCD counter.
// Ports    : master drives clear, load, load_value, enable, up and observes
//            bcd_out, carry_out, at_max, at_zero, load_err.
//            slave is the counter side of the same bundle.
// Revision : 1.0  initial release
// ============================================================================
interface bcd_counter_ndigit_if #(
    parameter int DIGITS = 4
) ();
    import bcd_pkg::*;

    logic                  clear;
    logic                  load;
    logic [4*DIGITS-1:0]   load_value;
    logic                  enable;
    logic                  up;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  carry_out;
    logic                  at_max;
    logic                  at_zero;
    logic                  load_err;

    modport master (
        output clear, load, load_value, enable, up,
        input  bcd_out, carry_out, at_max, at_zero, load_err
    );

    modport slave (
        input  clear, load, load_value, enable, up,
        output bcd_out, carry_out, at_max, at_zero, load_err
    );

endinterface : bcd_counter_ndigit_if
`default_nettype wire

// File: rtl/bcd_counter_ndigit_step.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit_step
// Purpose  : One BCD digit of the ripple increment/decrement chain.
//            Pure combinational.
// Ports    : digit_in  (in,  4)  current digit
//            up        (in,  1)  1: increment, 0: decrement
//            cin       (in,  1)  carry (up) or borrow (down) from lower digit
//            digit_out (out, 4)  stepped digit
//            cout      (out, 1)  carry/borrow into the next digit
// Revision : 1.0  initial release
// ============================================================================
module bcd_digit_step
    import bcd_pkg::*;
(
    input  bcd_digit_t digit_in,
    input  logic       up,
    input  logic       cin,
    output bcd_digit_t digit_out,
    output logic       cout
);

    always_comb begin
        digit_out = digit_in;
        cout      = 1'b0;
        if (cin) begin
            if (up) begin
                // >= rather than == keeps the digit bounded even if an
                // illegal value were ever present.
                if (digit_in >= BCD_MAX_DIGIT) begin
                    digit_out = 4'd0;
                    cout      = 1'b1;
                end else begin
                    digit_out = digit_in + 4'd1;
                end
            end else begin
                if (digit_in == 4'd0) begin
                    digit_out = BCD_MAX_DIGIT;
                    cout      = 1'b1;
                end else begin
                    digit_out = digit_in - 4'd1;
                end
            end
        end
    end

endmodule : bcd_digit_step
`default_nettype wire

// File: rtl/bcd_counter_ndigit.sv
`default_nettype none
// ============================================================================
// Module   : bcd_counter_ndigit
// Purpose  : Registered N-digit packed-BCD up/down counter with load,
//            synchronous clear and selectable wrap or saturate at the limits.
// Params   : DIGITS   number of BCD digits (1..8), digit 0 in [3:0]
//            SATURATE 0: wrap at the limits, 1: hold at max / zero
//            RST_VAL  reset and clear value, packed BCD
// Ports    : clk    (in, 1)  rising-edge clock
//            rst_n  (in, 1)  asynchronous active-low reset
//            bus    (slave)  clear/load/load_value/enable/up in,
//                            bcd_out/carry_out/at_max/at_zero/load_err out
// Revision : 1.0  initial release
// ============================================================================
module bcd_counter_ndigit
    import bcd_pkg::*;
#(
    parameter int                  DIGITS   = 4,
    parameter bit                  SATURATE = 1'b0,
    parameter logic [4*DIGITS-1:0] RST_VAL  = '0
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    bcd_counter_ndigit_if.slave bus
);

    localparam int C_WIDTH = 4 * DIGITS;

    logic [C_WIDTH-1:0] r_bcd;
    logic               r_carry;
    logic               r_load_err;

    logic [C_WIDTH-1:0] w_step;
    logic [DIGITS:0]    w_chain;
    logic [DIGITS-1:0]  w_nib_ok;
    logic [DIGITS-1:0]  w_dig_max;
    logic [C_WIDTH-1:0] w_bcd_next;
    logic               w_carry_next;
    logic               w_err_next;

    if ((DIGITS < 1) || (DIGITS > 8)) begin : g_bad_digits
        $error("bcd_counter_ndigit: DIGITS must be in 1..8");
    end

    // The lowest digit always steps; each higher digit steps only when all
    // digits below it rolled over. w_chain[DIGITS] flags the range limit.
    assign w_chain[0] = 1'b1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_step u_step (
            .digit_in  (r_bcd[4*g +: 4]),
            .up        (bus.up),
            .cin       (w_chain[g]),
            .digit_out (w_step[4*g +: 4]),
            .cout      (w_chain[g+1])
        );

        assign w_nib_ok[g]  = bcd_valid(bus.load_value[4*g +: 4]);
        assign w_dig_max[g] = (r_bcd[4*g +: 4] == BCD_MAX_DIGIT);

        if (RST_VAL[4*g +: 4] > BCD_MAX_DIGIT) begin : g_bad_rst_val
            $error("bcd_counter_ndigit: RST_VAL contains a non-BCD nibble");
        end
    end

    // Priority: clear > load > enable; the losers are ignored this cycle.
    always_comb begin
        w_bcd_next   = r_bcd;
        w_carry_next = 1'b0;
        w_err_next   = 1'b0;
        if (bus.clear) begin
            w_bcd_next = RST_VAL;
        end else if (bus.load) begin
            if (&w_nib_ok) begin
                w_bcd_next = bus.load_value;
            end else begin
                w_err_next = 1'b1;
            end
        end else if (bus.enable) begin
            w_carry_next = w_chain[DIGITS];
            // In saturate mode a blocked limit step still reports carry_out
            // so a cascaded consumer can see the attempted overflow.
            if (!(SATURATE && w_chain[DIGITS])) begin
                w_bcd_next = w_step;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcd      <= RST_VAL;
            r_carry    <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_bcd      <= w_bcd_next;
            r_carry    <= w_carry_next;
            r_load_err <= w_err_next;
        end
    end

    assign bus.bcd_out   = r_bcd;
    assign bus.carry_out = r_carry;
    assign bus.load_err  = r_load_err;
    assign bus.at_max    = &w_dig_max;
    assign bus.at_zero   = (r_bcd == '0);

endmodule : bcd_counter_ndigit
`default_nettype wire
